// File: rtl/imem_pkg.sv
// Shared constants and state encoding for the instruction memory responder.
// Holds the RISC-V NOP word and the LOAD/RUN state enum.
package imem_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/imem_ram.sv
// Instruction storage: one write port, one registered read port, no reset.
// The read port is read-first; same-edge bypass is handled by the owner.
module imem_ram #(
  parameter int DW = 32,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] rd
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    rd <= mem[ra];
  end

endmodule

// File: rtl/imem_responder.sv
// Loads a program over a valid/ready port, then serves it to the CPU.
// Define IMEM_BOUNDS_CHECK_EN to trap misaligned/out-of-range fetches.
module imem_responder
  import imem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DAT_WIDTH  = 32,
  parameter int DEPTH      = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ld_valid_i,
  output logic                       ld_ready_o,
  input  logic [DAT_WIDTH-1:0]       ld_data_i,
  input  logic                       ld_last_i,
  input  logic                       ld_restart_i,
  output logic [$clog2(DEPTH):0]     ld_count_o,
  output logic                       run_o,
  input  logic [ADDR_WIDTH-1:0]      PC_i,
  input  logic [ADDR_WIDTH-1:0]      next_PC_i,
  output logic [DAT_WIDTH-1:0]       im_o,
  output logic                       fault_o
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  state_e state_q, state_d;

  logic [CW-1:0]        cnt_q;
  logic                 accept;
  logic                 go_run;
  logic                 we;
  logic                 bad_pc;
  logic                 unused_pc;
  logic                 nop_q;
  logic                 byp_q;
  logic                 fault_q;
  logic [IW-1:0]        rd_addr;
  logic [DAT_WIDTH-1:0] rd_data;
  logic [DAT_WIDTH-1:0] byp_data_q;

  // Restart wins over a same-cycle load word.
  assign accept  = (state_q == LOAD) && ld_valid_i && !ld_restart_i;
  assign go_run  = accept &&
                   (ld_last_i || cnt_q == CW'(DEPTH - 1));
  assign we      = accept && rst_n;
  assign rd_addr = go_run ? '0 : next_PC_i[IW+1:2];

`ifdef IMEM_BOUNDS_CHECK_EN
  assign bad_pc    = (next_PC_i[1:0] != 2'b00) ||
                     ((next_PC_i >> (IW + 2)) != '0);
  assign unused_pc = ^PC_i;
`else
  assign bad_pc    = 1'b0;
  assign unused_pc = ^{PC_i, next_PC_i[1:0],
                       next_PC_i[ADDR_WIDTH-1:IW+2]};
`endif

  imem_ram #(
    .DW (DAT_WIDTH),
    .AW (IW)
  ) u_ram (
    .clk (clk),
    .we  (we),
    .wa  (cnt_q[IW-1:0]),
    .wd  (ld_data_i),
    .ra  (rd_addr),
    .rd  (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= LOAD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD: if (go_run) state_d = RUN;
      RUN:  if (ld_restart_i) state_d = LOAD;
    endcase
  end

  always_comb begin
    ld_ready_o = 1'b0;
    run_o      = 1'b0;
    unique case (state_q)
      LOAD: ld_ready_o = 1'b1;
      RUN:  run_o      = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || ld_restart_i)
      cnt_q <= '0;
    else if (accept && cnt_q != CW'(DEPTH))
      cnt_q <= cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nop_q   <= 1'b1;
      byp_q   <= 1'b0;
      fault_q <= 1'b0;
    end else if (ld_restart_i) begin
      nop_q   <= 1'b1;
      byp_q   <= 1'b0;
      fault_q <= 1'b0;
    end else if (state_q == LOAD) begin
      nop_q <= !go_run;
      byp_q <= go_run && cnt_q == '0;
    end else begin
      nop_q <= bad_pc;
      byp_q <= 1'b0;
      if (bad_pc) fault_q <= 1'b1;
    end
  end

  // Word 0 written on the start edge is not yet visible in the RAM read.
  always_ff @(posedge clk) begin
    byp_data_q <= ld_data_i;
  end

  assign im_o = nop_q ? DAT_WIDTH'(NOP) :
                byp_q ? byp_data_q : rd_data;

  assign ld_count_o = cnt_q;
  assign fault_o    = fault_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed and randomized checks of imem_responder against a
// behavioural program-memory model.
module tb_imem_responder;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOPW = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ld_valid_i = 1'b0;
  logic          ld_ready_o;
  logic [DW-1:0] ld_data_i = '0;
  logic          ld_last_i = 1'b0;
  logic          ld_restart_i = 1'b0;
  logic [CW-1:0] ld_count_o;
  logic          run_o;
  logic [AW-1:0] PC_i = '0;
  logic [AW-1:0] next_PC_i = '0;
  logic [DW-1:0] im_o;
  logic          fault_o;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] m_mem [DEPTH];
  int            m_cnt = 0;
  bit            m_run = 0;
  bit            m_fault = 0;
  logic [DW-1:0] m_im = NOPW;

  imem_responder #(
    .ADDR_WIDTH (AW),
    .DAT_WIDTH  (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ld_valid_i   (ld_valid_i),
    .ld_ready_o   (ld_ready_o),
    .ld_data_i    (ld_data_i),
    .ld_last_i    (ld_last_i),
    .ld_restart_i (ld_restart_i),
    .ld_count_o   (ld_count_o),
    .run_o        (run_o),
    .PC_i         (PC_i),
    .next_PC_i    (next_PC_i),
    .im_o         (im_o),
    .fault_o      (fault_o)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit pc_bad(logic [AW-1:0] pc);
`ifdef IMEM_BOUNDS_CHECK_EN
    return (pc % 4 != 0) || (pc >= 4 * DEPTH);
`else
    return 1'b0;
`endif
  endfunction

  // Program-memory behaviour expected across the coming edge.
  task automatic model_edge();
    if (!rst_n) begin
      m_run = 0; m_cnt = 0; m_im = NOPW; m_fault = 0;
    end else if (ld_restart_i) begin
      m_run = 0; m_cnt = 0; m_im = NOPW; m_fault = 0;
    end else if (!m_run) begin
      if (ld_valid_i) begin
        m_mem[m_cnt] = ld_data_i;
        m_cnt++;
        if (ld_last_i || m_cnt == DEPTH) begin
          m_run = 1;
          m_im  = m_mem[0];
        end
      end
    end else if (pc_bad(next_PC_i)) begin
      m_im = NOPW; m_fault = 1;
    end else begin
      m_im = m_mem[(next_PC_i / 4) % DEPTH];
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("ld_count", 64'(ld_count_o), 64'(m_cnt));
    chk("run", 64'(run_o), 64'(m_run));
    chk("ready", 64'(ld_ready_o), 64'(!m_run));
    chk("im", 64'(im_o), 64'(m_im));
    chk("fault", 64'(fault_o), 64'(m_fault));
    PC_i = next_PC_i;
  endtask

  task automatic load_word(logic [DW-1:0] d, bit last);
    ld_valid_i = 1'b1;
    ld_data_i  = d;
    ld_last_i  = last;
    step();
    ld_valid_i = 1'b0;
    ld_last_i  = 1'b0;
  endtask

  task automatic run_pc(logic [AW-1:0] pc);
    next_PC_i = pc;
    step();
  endtask

  task automatic restart();
    ld_restart_i = 1'b1;
    step();
    ld_restart_i = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] prog [4];
    prog[0] = 32'h0050_0093;
    prog[1] = 32'h00A0_0113;
    prog[2] = 32'h0020_81B3;
    prog[3] = 32'h0000_0013;

    rst_n = 1'b0;
    step();
    step();
    chk("rst_im", 64'(im_o), 64'(NOPW));
    chk("rst_ready", 64'(ld_ready_o), 64'd1);
    rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) load_word($urandom, 1'b0);
    chk("full_cnt", 64'(ld_count_o), 64'(DEPTH));
    chk("full_run", 64'(run_o), 64'd1);
    next_PC_i = '0;
    ld_valid_i = 1'b1;
    ld_data_i  = $urandom;
    step();
    step();
    ld_valid_i = 1'b0;
    chk("extra_ignored", 64'(ld_count_o), 64'(DEPTH));

    restart();
    for (int i = 0; i < 4; i++) load_word(prog[i], i == 3);
    chk("p_cnt", 64'(ld_count_o), 64'd4);
    chk("p_run", 64'(run_o), 64'd1);
    chk("p_im0", 64'(im_o), 64'h0050_0093);
    run_pc(32'h4);
    chk("p_im1", 64'(im_o), 64'h00A0_0113);
    run_pc(32'h8);
    chk("p_im2", 64'(im_o), 64'h0020_81B3);
    run_pc(32'hC);
    chk("p_im3", 64'(im_o), 64'h0000_0013);

    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) run_pc(32'($urandom_range(0, DEPTH - 1) * 4));
      else            run_pc($urandom);
    end

    restart();
    for (int i = 0; i < 4; i++) load_word(prog[i], i == 3);
    run_pc(32'h2);
    run_pc(32'(4 * DEPTH));
`ifdef IMEM_BOUNDS_CHECK_EN
    chk("oob_im", 64'(im_o), 64'(NOPW));
    chk("oob_fault", 64'(fault_o), 64'd1);
    run_pc(32'h0);
    chk("fault_held", 64'(fault_o), 64'd1);
`else
    chk("wrap_im", 64'(im_o), 64'h0050_0093);
    chk("wrap_fault", 64'(fault_o), 64'd0);
`endif

    restart();
    load_word(32'h0010_0093, 1'b1);
    chk("rl_im0", 64'(im_o), 64'h0010_0093);
    chk("rl_cnt", 64'(ld_count_o), 64'd1);
    run_pc(32'h4);
    chk("rl_im1", 64'(im_o), 64'h00A0_0113);
    run_pc(32'h8);
    chk("rl_im2", 64'(im_o), 64'h0020_81B3);
    run_pc(32'hC);
    chk("rl_im3", 64'(im_o), 64'h0000_0013);

    for (int i = 0; i < 60; i++) begin
      ld_valid_i   = 1'($urandom % 2);
      ld_data_i    = $urandom;
      ld_last_i    = ($urandom % 4) == 0;
      ld_restart_i = ($urandom % 8) == 0;
      next_PC_i    = 32'($urandom_range(0, DEPTH - 1) * 4);
      step();
    end
    ld_valid_i   = 1'b0;
    ld_last_i    = 1'b0;
    ld_restart_i = 1'b0;

    restart();
    load_word($urandom, 1'b0);
    load_word($urandom, 1'b0);
    rst_n      = 1'b0;
    ld_valid_i = 1'b1;
    ld_data_i  = 32'hDEAD_BEEF;
    step();
    ld_valid_i = 1'b0;
    rst_n      = 1'b1;
    chk("mid_rst_cnt", 64'(ld_count_o), 64'd0);
    chk("mid_rst_run", 64'(run_o), 64'd0);
    chk("mid_rst_im", 64'(im_o), 64'(NOPW));
    load_word(32'h0010_0093, 1'b1);
    run_pc(32'h8);
    run_pc(32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
